// File: rtl/imem_port_arbiter_if.sv
// Bundle of the fetch, loader and instruction-memory handshakes around imem_port_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface imem_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    // Fetch requester (read only)
    logic              fetch_req_valid;
    logic [ADDR_W-1:0] fetch_req_addr;
    logic              fetch_req_ready;
    logic              fetch_flush;
    logic              fetch_resp_valid;
    logic [DATA_W-1:0] fetch_resp_data;

    // Loader / debug requester (read/write)
    logic              ld_req_valid;
    logic              ld_req_we;
    logic [ADDR_W-1:0] ld_req_addr;
    logic [DATA_W-1:0] ld_req_wdata;
    logic              ld_req_ready;
    logic              ld_resp_valid;
    logic [DATA_W-1:0] ld_resp_data;

    // Instruction memory port
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;

    modport slave (
        input  fetch_req_valid, fetch_req_addr, fetch_flush,
        output fetch_req_ready, fetch_resp_valid, fetch_resp_data,
        input  ld_req_valid, ld_req_we, ld_req_addr, ld_req_wdata,
        output ld_req_ready, ld_resp_valid, ld_resp_data,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport master (
        output fetch_req_valid, fetch_req_addr, fetch_flush,
        input  fetch_req_ready, fetch_resp_valid, fetch_resp_data,
        output ld_req_valid, ld_req_we, ld_req_addr, ld_req_wdata,
        input  ld_req_ready, ld_resp_valid, ld_resp_data,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// Round-robin arbiter sharing one instruction-memory port between fetch and loader, one transaction in flight.
// Optional response watchdog enabled by defining IMEM_ARB_TIMEOUT_EN.
module imem_port_arbiter #(
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    imem_port_arbiter_if.slave    bus,
    output logic                  err_timeout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_F = 2'd1,
        WAIT_L = 2'd2
    } state_t;

    localparam logic GNT_F = 1'b0;
    localparam logic GNT_L = 1'b1;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              kill_q, kill_d;
    logic              ld_we_q, ld_we_d;

    logic              fetch_resp_valid_q;
    logic [DATA_W-1:0] fetch_resp_data_q;
    logic              ld_resp_valid_q;
    logic [DATA_W-1:0] ld_resp_data_q;

    logic              grant_f;
    logic              grant_l;
    logic              accept;
    logic              timeout_hit;

    logic              mem_req_valid_w;
    logic              mem_req_we_w;
    logic [ADDR_W-1:0] mem_req_addr_w;
    logic [DATA_W-1:0] mem_req_wdata_w;
    logic              fetch_req_ready_w;
    logic              ld_req_ready_w;

    // On a tie the requester that did not win last time is granted.
    assign grant_f = bus.fetch_req_valid && (!bus.ld_req_valid || (last_grant_q == GNT_L));
    assign grant_l = bus.ld_req_valid && (!bus.fetch_req_valid || (last_grant_q == GNT_F));

    always_comb begin
        mem_req_valid_w   = 1'b0;
        mem_req_we_w      = 1'b0;
        mem_req_addr_w    = '0;
        mem_req_wdata_w   = '0;
        fetch_req_ready_w = 1'b0;
        ld_req_ready_w    = 1'b0;
        if (state_q == IDLE) begin
            if (grant_f) begin
                mem_req_valid_w   = 1'b1;
                mem_req_addr_w    = bus.fetch_req_addr;
                fetch_req_ready_w = bus.mem_req_ready;
            end else if (grant_l) begin
                mem_req_valid_w = 1'b1;
                mem_req_we_w    = bus.ld_req_we;
                mem_req_addr_w  = bus.ld_req_addr;
                mem_req_wdata_w = bus.ld_req_we ? bus.ld_req_wdata : '0;
                ld_req_ready_w  = bus.mem_req_ready;
            end
        end
    end

    assign accept = mem_req_valid_w && bus.mem_req_ready;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        kill_d       = kill_q;
        ld_we_d      = ld_we_q;
        case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (accept) begin
                    if (grant_f) begin
                        state_d      = WAIT_F;
                        last_grant_d = GNT_F;
                        // Memory still sees a fetch flushed in its issue cycle; only the response dies.
                        kill_d       = bus.fetch_flush;
                    end else begin
                        state_d      = WAIT_L;
                        last_grant_d = GNT_L;
                        ld_we_d      = bus.ld_req_we;
                    end
                end
            end
            WAIT_F: begin
                if (bus.fetch_flush) begin
                    kill_d = 1'b1;
                end
                if (bus.mem_resp_valid || timeout_hit) begin
                    state_d = IDLE;
                    kill_d  = 1'b0;
                end
            end
            WAIT_L: begin
                if (bus.mem_resp_valid || timeout_hit) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                kill_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_L;
            kill_q       <= 1'b0;
            ld_we_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            kill_q       <= kill_d;
            ld_we_q      <= ld_we_d;
        end
    end

    // Responses are registered; a flush in the response cycle also kills the fetch result.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_resp_valid_q <= 1'b0;
            fetch_resp_data_q  <= '0;
            ld_resp_valid_q    <= 1'b0;
            ld_resp_data_q     <= '0;
        end else begin
            fetch_resp_valid_q <= (state_q == WAIT_F) && bus.mem_resp_valid
                                  && !kill_q && !bus.fetch_flush;
            if ((state_q == WAIT_F) && bus.mem_resp_valid && !kill_q && !bus.fetch_flush) begin
                fetch_resp_data_q <= bus.mem_resp_data;
            end
            ld_resp_valid_q <= (state_q == WAIT_L) && bus.mem_resp_valid;
            if ((state_q == WAIT_L) && bus.mem_resp_valid) begin
                ld_resp_data_q <= ld_we_q ? '0 : bus.mem_resp_data;
            end
        end
    end

`ifdef IMEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Counter sits at zero in IDLE, so it restarts on every entry to a wait state.
    assign timeout_hit = (state_q != IDLE) && !bus.mem_resp_valid
                         && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = '0;
        err_d = err_q | timeout_hit;
        if (state_q != IDLE) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout_hit        = 1'b0;
    assign err_timeout        = 1'b0;
`endif

    assign bus.mem_req_valid    = mem_req_valid_w;
    assign bus.mem_req_we       = mem_req_we_w;
    assign bus.mem_req_addr     = mem_req_addr_w;
    assign bus.mem_req_wdata    = mem_req_wdata_w;
    assign bus.fetch_req_ready  = fetch_req_ready_w;
    assign bus.ld_req_ready     = ld_req_ready_w;
    assign bus.fetch_resp_valid = fetch_resp_valid_q && !bus.fetch_flush;
    assign bus.fetch_resp_data  = fetch_resp_data_q;
    assign bus.ld_resp_valid    = ld_resp_valid_q;
    assign bus.ld_resp_data     = ld_resp_data_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter: stimulus pushes expected requests/responses into queues,
// an independent negedge monitor pops and compares them whenever the DUT presents one.
module tb_imem_port_arbiter;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int TMO    = 8;

    logic clk = 1'b0;
    logic rst;
    logic err_timeout;

    int n_checks = 0;
    int n_pass   = 0;

    logic [ADDR_W+DATA_W:0] exp_mem_q[$];
    logic [DATA_W-1:0]      exp_f_q[$];
    logic [DATA_W-1:0]      exp_l_q[$];
    logic [ADDR_W+DATA_W:0] mon_mem;
    logic [DATA_W-1:0]      mon_d;

    imem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    imem_port_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.fetch_req_ready && bus.ld_req_ready)
                check("ready_exclusive", 64'd1, 64'd0);
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                $display("mem req  we=%0b addr=0x%0h wdata=0x%0h", bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata);
                if (exp_mem_q.size() == 0) begin
                    check("mem_req_unexpected", 64'(bus.mem_req_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    mon_mem = exp_mem_q.pop_front();
                    check("mem_req", 64'({bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata}), 64'(mon_mem));
                end
            end
            if (bus.fetch_resp_valid) begin
                $display("fetch resp data=0x%0h", bus.fetch_resp_data);
                if (exp_f_q.size() == 0) begin
                    check("fetch_resp_unexpected", 64'(bus.fetch_resp_data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    mon_d = exp_f_q.pop_front();
                    check("fetch_resp_data", 64'(bus.fetch_resp_data), 64'(mon_d));
                end
            end
            if (bus.ld_resp_valid) begin
                $display("ld resp  data=0x%0h", bus.ld_resp_data);
                if (exp_l_q.size() == 0) begin
                    check("ld_resp_unexpected", 64'(bus.ld_resp_data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    mon_d = exp_l_q.pop_front();
                    check("ld_resp_data", 64'(bus.ld_resp_data), 64'(mon_d));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(output int n);
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (bus.mem_req_valid && bus.mem_req_ready) break;
            n++;
        end
        if (n >= 50) check("accept_bound", 64'd0, 64'd1);
        tick();
    endtask

    task automatic mem_resp_pulse(input logic [DATA_W-1:0] d);
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = d;
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
    endtask

    task automatic fetch_txn(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int n;
        exp_mem_q.push_back({1'b0, a, 32'd0});
        exp_f_q.push_back(d);
        bus.fetch_req_valid = 1'b1;
        bus.fetch_req_addr  = a;
        wait_accept(n);
        check("fetch_accept_wait", 64'(n), 64'd0);
        bus.fetch_req_valid = 1'b0;
        tick();
        mem_resp_pulse(d);
        @(negedge clk);
        check("fetch_resp_valid", 64'(bus.fetch_resp_valid), 64'd1);
        tick();
    endtask

    task automatic ld_txn(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                          input logic [DATA_W-1:0] rd, input logic [DATA_W-1:0] exp_d, input logic flush);
        int n;
        exp_mem_q.push_back({we, a, (we ? wd : 32'd0)});
        exp_l_q.push_back(exp_d);
        bus.ld_req_valid = 1'b1;
        bus.ld_req_we    = we;
        bus.ld_req_addr  = a;
        bus.ld_req_wdata = wd;
        wait_accept(n);
        check("ld_accept_wait", 64'(n), 64'd0);
        bus.ld_req_valid = 1'b0;
        bus.fetch_flush  = flush;
        tick();
        bus.fetch_flush  = 1'b0;
        mem_resp_pulse(rd);
        @(negedge clk);
        check("ld_resp_valid", 64'(bus.ld_resp_valid), 64'd1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got no finish, required finish");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        logic [DATA_W-1:0] cont_d[4];
        cont_d[0] = 32'h0000_F001; cont_d[1] = 32'h0000_1D01;
        cont_d[2] = 32'h0000_F002; cont_d[3] = 32'h0000_1D02;

        rst = 1'b1;
        bus.fetch_req_valid = 1'b0; bus.fetch_req_addr = '0; bus.fetch_flush = 1'b0;
        bus.ld_req_valid = 1'b0; bus.ld_req_we = 1'b0; bus.ld_req_addr = '0; bus.ld_req_wdata = '0;
        bus.mem_req_ready = 1'b1; bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_fetch_resp_valid", 64'(bus.fetch_resp_valid), 64'd0);
        check("rst_ld_resp_valid", 64'(bus.ld_resp_valid), 64'd0);
        check("rst_fetch_resp_data", 64'(bus.fetch_resp_data), 64'd0);
        check("rst_ld_resp_data", 64'(bus.ld_resp_data), 64'd0);
        check("rst_err_timeout", 64'(err_timeout), 64'd0);
        check("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
        tick();

        // Contention straight out of reset: F, L, F, L
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                exp_mem_q.push_back({1'b0, 10'h030, 32'd0});
                exp_f_q.push_back(cont_d[i]);
            end else begin
                exp_mem_q.push_back({1'b0, 10'h031, 32'd0});
                exp_l_q.push_back(cont_d[i]);
            end
        end
        bus.fetch_req_valid = 1'b1; bus.fetch_req_addr = 10'h030;
        bus.ld_req_valid = 1'b1; bus.ld_req_we = 1'b0; bus.ld_req_addr = 10'h031;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("cont_grant_valid", 64'(bus.mem_req_valid), 64'd1);
            check("cont_fetch_ready", 64'(bus.fetch_req_ready), 64'((i % 2) == 0));
            check("cont_ld_ready", 64'(bus.ld_req_ready), 64'((i % 2) == 1));
            tick();
            if (i == 3) begin
                bus.fetch_req_valid = 1'b0;
                bus.ld_req_valid    = 1'b0;
            end
            tick();
            mem_resp_pulse(cont_d[i]);
            @(negedge clk);
            if (i % 2 == 0) check("cont_fetch_resp", 64'(bus.fetch_resp_valid), 64'd1);
            else            check("cont_ld_resp", 64'(bus.ld_resp_valid), 64'd1);
        end
        tick();

        // Fetch read
        fetch_txn(10'h010, 32'hDEADBEEF);

        // Loader write then read-back (flush during the read must not matter)
        ld_txn(1'b1, 10'h005, 32'h12345678, 32'hFFFF_FFFF, 32'h0, 1'b0);
        ld_txn(1'b0, 10'h005, 32'hCAFE_0000, 32'h12345678, 32'h12345678, 1'b1);

        // Flush while waiting
        exp_mem_q.push_back({1'b0, 10'h040, 32'd0});
        bus.fetch_req_valid = 1'b1; bus.fetch_req_addr = 10'h040;
        wait_accept(n);
        bus.fetch_req_valid = 1'b0;
        bus.fetch_flush = 1'b1;
        tick();
        bus.fetch_flush = 1'b0;
        mem_resp_pulse(32'hAAAA0000);
        @(negedge clk);
        check("killed_fetch_wait", 64'(bus.fetch_resp_valid), 64'd0);
        tick();
        fetch_txn(10'h020, 32'h0000_1111);

        // Flush in the issue cycle
        exp_mem_q.push_back({1'b0, 10'h044, 32'd0});
        bus.fetch_req_valid = 1'b1; bus.fetch_req_addr = 10'h044; bus.fetch_flush = 1'b1;
        wait_accept(n);
        bus.fetch_req_valid = 1'b0; bus.fetch_flush = 1'b0;
        tick();
        mem_resp_pulse(32'h0000_BBBB);
        @(negedge clk);
        check("killed_fetch_issue", 64'(bus.fetch_resp_valid), 64'd0);
        tick();

        // Flush in the cycle the registered response is presented
        exp_mem_q.push_back({1'b0, 10'h024, 32'd0});
        bus.fetch_req_valid = 1'b1; bus.fetch_req_addr = 10'h024;
        wait_accept(n);
        bus.fetch_req_valid = 1'b0;
        tick();
        mem_resp_pulse(32'h0000_2222);
        bus.fetch_flush = 1'b1;
        @(negedge clk);
        check("killed_fetch_present", 64'(bus.fetch_resp_valid), 64'd0);
        tick();
        bus.fetch_flush = 1'b0;
        fetch_txn(10'h028, 32'h0000_2828);

        // Memory backpressure
        bus.mem_req_ready = 1'b0;
        bus.fetch_req_valid = 1'b1; bus.fetch_req_addr = 10'h050;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_fetch_ready", 64'(bus.fetch_req_ready), 64'd0);
            check("bp_mem_addr", 64'(bus.mem_req_addr), 64'h050);
        end
        tick();
        exp_mem_q.push_back({1'b0, 10'h050, 32'd0});
        exp_f_q.push_back(32'h0000_5555);
        bus.mem_req_ready = 1'b1;
        wait_accept(n);
        check("bp_accept_wait", 64'(n), 64'd0);
        bus.fetch_req_valid = 1'b0;
        tick();
        mem_resp_pulse(32'h0000_5555);
        @(negedge clk);
        check("bp_fetch_resp", 64'(bus.fetch_resp_valid), 64'd1);
        tick();

        // Reset in WAIT_L, then a late memory response
        exp_mem_q.push_back({1'b0, 10'h060, 32'd0});
        bus.ld_req_valid = 1'b1; bus.ld_req_we = 1'b0; bus.ld_req_addr = 10'h060;
        wait_accept(n);
        bus.ld_req_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_resp_pulse(32'h0000_0BAD);
        @(negedge clk);
        check("late_resp_ld_valid", 64'(bus.ld_resp_valid), 64'd0);
        check("rst_ld_resp_data_clr", 64'(bus.ld_resp_data), 64'd0);
        tick();
        fetch_txn(10'h070, 32'h0000_7777);

        // Watchdog
        exp_mem_q.push_back({1'b0, 10'h07C, 32'd0});
`ifndef IMEM_ARB_TIMEOUT_EN
        exp_f_q.push_back(32'h0000_7C7C);
`endif
        bus.fetch_req_valid = 1'b1; bus.fetch_req_addr = 10'h07C;
        wait_accept(n);
        bus.fetch_req_valid = 1'b0;
        repeat (TMO - 1) tick();
        @(negedge clk);
        check("err_before_limit", 64'(err_timeout), 64'd0);
        tick();
`ifdef IMEM_ARB_TIMEOUT_EN
        @(negedge clk);
        check("err_at_limit", 64'(err_timeout), 64'd1);
        tick();
        fetch_txn(10'h07D, 32'h0000_7D7D);
        check("err_sticky", 64'(err_timeout), 64'd1);
`else
        bus.fetch_req_valid = 1'b1; bus.fetch_req_addr = 10'h07D;
        @(negedge clk);
        check("err_tied_low", 64'(err_timeout), 64'd0);
        check("still_waiting", 64'(bus.fetch_req_ready), 64'd0);
        tick();
        bus.fetch_req_valid = 1'b0;
        mem_resp_pulse(32'h0000_7C7C);
        @(negedge clk);
        check("late_fetch_resp", 64'(bus.fetch_resp_valid), 64'd1);
        tick();
`endif

        repeat (3) tick();
        check("exp_mem_drained", 64'(exp_mem_q.size()), 64'd0);
        check("exp_fetch_drained", 64'(exp_f_q.size()), 64'd0);
        check("exp_ld_drained", 64'(exp_l_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
